// File: rtl/dequant_feeder.sv
// dequant_feeder: FIFO-buffered int8x4 dequantizer with diagonal skew into array rows.
// Optional rounding build: define DEQUANT_FEEDER_ROUND_EN (round half toward +inf).
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : input handshake; in_data = 4 x int8 lanes, in_last = end of frame
//   scale, shift      : dequant multiplier / arithmetic right shift, sampled at pop
//   advance           : array step enable; low freezes pop, skew pipeline, drain counter
//   a0..a3, a_valid   : skewed 18-bit signed row operands and per-lane valids
//   busy, done        : frame in progress / one-cycle end-of-drain pulse
module dequant_feeder #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  input  logic [7:0]  scale,
  input  logic [3:0]  shift,
  input  logic        advance,
  output logic [17:0] a0,
  output logic [17:0] a1,
  output logic [17:0] a2,
  output logic [17:0] a3,
  output logic [3:0]  a_valid,
  output logic        busy,
  output logic        done
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FEED  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [32:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic [1:0]    r_state;
  logic [1:0]    r_dcnt;

  // skew lanes carry {valid, value}
  logic [18:0] r_s0 [4];
  logic [18:0] r_l1;
  logic [18:0] r_l2 [2];
  logic [18:0] r_l3 [3];

  logic               w_push;
  logic               w_pop;
  logic [32:0]        w_word;
  logic signed [17:0] w_deq [4];

  function automatic logic signed [17:0] deq(
    input logic [7:0] lane,
    input logic [7:0] sc,
    input logic [3:0] sh
  );
    logic signed [16:0] p;
    logic signed [17:0] e;
    logic [17:0]        rnd;
    p = $signed({{9{lane[7]}}, lane}) * $signed({9'd0, sc});
    e = {p[16], p};
`ifdef DEQUANT_FEEDER_ROUND_EN
    rnd = (sh == 4'd0) ? 18'd0 : (18'd1 << (sh - 4'd1));
`else
    rnd = 18'd0;
`endif
    e = e + $signed(rnd);
    return e >>> sh;
  endfunction

  assign in_ready = (r_count != FULL);
  assign w_push   = in_valid && in_ready;
  assign w_pop    = advance && (r_count != '0) && (r_state != S_DRAIN);
  assign w_word   = r_mem[r_rptr];

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_deq[k] = deq(w_word[8*k +: 8], scale, shift);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {in_last, in_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + {{AW{1'b0}}, w_push}
                         - {{AW{1'b0}}, w_pop};
    end
  end

  // bubbles (value 0, valid 0) are injected on non-pop advance cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) r_s0[k] <= '0;
      r_l1 <= '0;
      for (int k = 0; k < 2; k++) r_l2[k] <= '0;
      for (int k = 0; k < 3; k++) r_l3[k] <= '0;
    end else if (advance) begin
      for (int k = 0; k < 4; k++) begin
        r_s0[k] <= w_pop ? {1'b1, w_deq[k]} : '0;
      end
      r_l1    <= r_s0[1];
      r_l2[0] <= r_s0[2];
      r_l2[1] <= r_l2[0];
      r_l3[0] <= r_s0[3];
      r_l3[1] <= r_l3[0];
      r_l3[2] <= r_l3[1];
    end
  end

  // drain counter wraps 3->0 as the state returns to IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_dcnt  <= '0;
    end else if (advance) begin
      unique case (r_state)
        S_IDLE, S_FEED: begin
          if (w_pop) begin
            r_dcnt  <= '0;
            r_state <= w_word[32] ? S_DRAIN : S_FEED;
          end
        end
        S_DRAIN: begin
          r_dcnt <= r_dcnt + 2'd1;
          if (r_dcnt == 2'd3) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign a0 = r_s0[0][17:0];
  assign a1 = r_l1[17:0];
  assign a2 = r_l2[1][17:0];
  assign a3 = r_l3[2][17:0];

  assign a_valid = {r_l3[2][18], r_l2[1][18], r_l1[18], r_s0[0][18]};

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DRAIN) && (r_dcnt == 2'd3);

endmodule

// File: tb/tb_dequant_feeder.sv
// tb_dequant_feeder: directed scenarios plus random traffic against a
// behavioural model (word queue, tick-indexed delay history, drain lock).
module tb_dequant_feeder;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        advance = 1'b0;
  logic [31:0] in_data = '0;
  logic [7:0]  scale = '0;
  logic [3:0]  shift = '0;
  logic        in_ready;
  logic [17:0] a0, a1, a2, a3;
  logic [3:0]  a_valid;
  logic        busy, done;

  dequant_feeder #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last),
    .scale(scale), .shift(shift), .advance(advance),
    .a0(a0), .a1(a1), .a2(a2), .a3(a3),
    .a_valid(a_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  task automatic check(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int deq_ref(input int lane, input int sc, input int sh);
    int p;
    p = lane * sc;
`ifdef DEQUANT_FEEDER_ROUND_EN
    if (sh > 0) p = p + (1 << (sh - 1));
`endif
    return p >>> sh;
  endfunction

  // model: hx[s][lane] is the word injected s advance-ticks ago;
  // lane k is visible at history slot k. lock counts remaining drain ticks.
  logic [32:0] mq [$];
  int  hx [4][4];
  bit  hvld [4];
  int  lock = 0;
  bit  inframe = 0;
  bit  started = 0;
  logic [32:0] m_w;
  bit  m_pop, m_push;
  byte m_b;

  always @(posedge clk) begin
    started = 1;
    if (rst) begin
      mq.delete();
      lock = 0;
      inframe = 0;
      for (int s = 0; s < 4; s++) begin
        hvld[s] = 0;
        for (int l = 0; l < 4; l++) hx[s][l] = 0;
      end
    end else begin
      m_pop  = advance && (mq.size() != 0) && (lock == 0);
      m_push = in_valid && (mq.size() < DEPTH);
      if (advance) begin
        for (int s = 3; s > 0; s--) begin
          hvld[s] = hvld[s-1];
          for (int l = 0; l < 4; l++) hx[s][l] = hx[s-1][l];
        end
        hvld[0] = 0;
        for (int l = 0; l < 4; l++) hx[0][l] = 0;
        if (lock > 0) lock--;
        if (m_pop) begin
          m_w = mq.pop_front();
          hvld[0] = 1;
          for (int l = 0; l < 4; l++) begin
            m_b = m_w[8*l +: 8];
            hx[0][l] = deq_ref(int'(m_b), int'(scale), int'(shift));
          end
          if (m_w[32]) begin
            lock = 4;
            inframe = 0;
          end else begin
            inframe = 1;
          end
        end
      end
      if (m_push) mq.push_back({in_last, in_data});
    end
  end

  always @(negedge clk) begin
    if (started) begin
      int eav;
      eav = 0;
      for (int k = 0; k < 4; k++) eav = eav | (int'(hvld[k]) << k);
      check("a0", int'($signed(a0)), hx[0][0]);
      check("a1", int'($signed(a1)), hx[1][1]);
      check("a2", int'($signed(a2)), hx[2][2]);
      check("a3", int'($signed(a3)), hx[3][3]);
      check("a_valid", int'(a_valid), eav);
      check("in_ready", int'(in_ready), (mq.size() < DEPTH) ? 1 : 0);
      check("busy", int'(busy), (inframe || lock > 0) ? 1 : 0);
      check("done", int'(done), (lock == 1) ? 1 : 0);
    end
  end

  task automatic push1(input logic [31:0] d, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("push_accept", int'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic single_word();
    int ev [4];
    ev = '{-2, 2, 254, -256};
    advance = 1'b1;
    scale = 8'd2;
    shift = 4'd0;
    push1(32'h807F01FF, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("sw_valid", int'(a_valid), 1 << (k - 1));
      check("sw_busy", int'(busy), 1);
      unique case (k)
        1: check("sw_a0", int'($signed(a0)), ev[0]);
        2: check("sw_a1", int'($signed(a1)), ev[1]);
        3: check("sw_a2", int'($signed(a2)), ev[2]);
        default: check("sw_a3", int'($signed(a3)), ev[3]);
      endcase
      check("sw_done", int'(done), (k == 4) ? 1 : 0);
    end
    @(negedge clk);
    check("sw_done_end", int'(done), 0);
    check("sw_busy_end", int'(busy), 0);
  endtask

  int pat [7] = '{1, 1, 0, 0, 0, 0, 1};
  int r1, r2;

  initial begin
`ifdef DEQUANT_FEEDER_ROUND_EN
    r1 = 2;
    r2 = -1;
`else
    r1 = 1;
    r2 = -2;
`endif
    check("ref_pos", deq_ref(3, 1, 1), r1);
    check("ref_neg", deq_ref(-3, 1, 1), r2);

    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ready", int'(in_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(a_valid), 0);
    check("rst_done", int'(done), 0);
    rst = 1'b0;

    single_word();

    // rounding
    advance = 1'b0;
    push1(32'h00000003, 1'b0);
    push1(32'h000000FD, 1'b1);
    scale = 8'd1;
    shift = 4'd1;
    advance = 1'b1;
    @(negedge clk);
    check("rnd_pos", int'($signed(a0)), r1);
    @(negedge clk);
    check("rnd_neg", int'($signed(a0)), r2);
    repeat (6) @(negedge clk);

    // backpressure
    advance = 1'b0;
    scale = 8'd3;
    shift = 4'd2;
    for (int i = 0; i < 4; i++) push1(32'h11223344 * (i + 1), 1'b0);
    check("bp_full", int'(in_ready), 0);
    in_valid = 1'b1;
    in_data  = 32'hA5C3_7F80;
    in_last  = 1'b1;
    repeat (2) @(negedge clk);
    check("bp_held", int'(in_ready), 0);
    advance = 1'b1;
    @(negedge clk);
    check("bp_reopen", int'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (12) @(negedge clk);

    // stall mid-stream
    scale = 8'd200;
    shift = 4'd5;
    push1(32'h01F0_7F81, 1'b0);
    push1(32'h80FF_1234, 1'b0);
    push1(32'h7E02_C3E5, 1'b1);
    advance = 1'b0;
    repeat (2) @(negedge clk);
    advance = 1'b1;
    repeat (10) @(negedge clk);

    // back-to-back frames
    advance = 1'b0;
    scale = 8'd1;
    shift = 4'd0;
    push1(32'h0403_0201, 1'b0);
    push1(32'h0807_0605, 1'b1);
    push1(32'h0C0B_0A09, 1'b1);
    advance = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("b2b_pop", int'(a_valid[0]), pat[i]);
      if (i == 4) check("b2b_done", int'(done), 1);
    end
    repeat (8) @(negedge clk);

    // reset during drain
    scale = 8'd2;
    push1(32'h1234_5678, 1'b1);
    repeat (2) @(negedge clk);
    check("rd_busy_pre", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rd_a0", int'(a0), 0);
    check("rd_a3", int'(a3), 0);
    check("rd_valid", int'(a_valid), 0);
    check("rd_ready", int'(in_ready), 1);
    check("rd_busy", int'(busy), 0);
    check("rd_done", int'(done), 0);
    repeat (3) begin
      @(negedge clk);
      check("rd_nodone", int'(done), 0);
    end
    single_word();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      in_valid = 1'($urandom % 2);
      in_data  = $urandom;
      in_last  = ($urandom % 4) == 0;
      scale    = 8'($urandom);
      shift    = 4'($urandom);
      advance  = ($urandom % 4) != 0;
      rst      = ($urandom % 400) == 0;
      @(negedge clk);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    advance = 1'b1;
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
